// File: rtl/cic_pkg.sv
// Shared arithmetic helpers for the CIC integrator and comb sections.
//   cic_mode_e : wrap-around or saturating accumulation
//   add_ovf    : width-limited signed add with overflow flag and optional clamp
package cic_pkg;

  localparam int unsigned CIC_MAX_W = 64;

  typedef enum logic {
    CIC_WRAP = 1'b0,
    CIC_SAT  = 1'b1
  } cic_mode_e;

  typedef struct packed {
    logic                 ovf;
    logic [CIC_MAX_W-1:0] sum;
  } cic_add_t;

  // Operands are sign-extended to CIC_MAX_W; only sum[width-1:0] is meaningful.
  function automatic cic_add_t add_ovf(input logic [CIC_MAX_W-1:0] a,
                                       input logic [CIC_MAX_W-1:0] b,
                                       input int unsigned          width,
                                       input cic_mode_e            mode);
    cic_add_t             r;
    logic [CIC_MAX_W-1:0] raw;
    logic [CIC_MAX_W-1:0] max_v;
    logic [CIC_MAX_W-1:0] min_v;
    logic [5:0]           msb;
    logic                 sa;
    logic                 sb;
    msb   = 6'(width - 1);
    raw   = a + b;
    sa    = a[msb];
    sb    = b[msb];
    max_v = (CIC_MAX_W'(1) << msb) - CIC_MAX_W'(1);
    min_v = ~max_v;
    // Same-sign operands whose sum flips sign have left the representable range.
    r.ovf = (sa == sb) && (raw[msb] != sa);
    r.sum = raw;
    if (mode == CIC_SAT && r.ovf) begin
      r.sum = sa ? min_v : max_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_integrator_chain_if.sv
// Sample/result bundle of the CIC integrator chain.
//   master : sample source (drives in_valid, in_data, clear, clr_ovf)
//   slave  : integrator chain (drives out_valid, out_data, ovf_pulse, ovf_sticky)
interface cic_integrator_chain_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned N_STAGES  = 3
);

  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        clear;
  logic                        clr_ovf;
  logic                        out_valid;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic [N_STAGES-1:0]         ovf_pulse;
  logic [N_STAGES-1:0]         ovf_sticky;

  modport master (
    output in_valid, in_data, clear, clr_ovf,
    input  out_valid, out_data, ovf_pulse, ovf_sticky
  );

  modport slave (
    input  in_valid, in_data, clear, clr_ovf,
    output out_valid, out_data, ovf_pulse, ovf_sticky
  );

endinterface

// File: rtl/cic_integrator_stage.sv
// One signed integrator: acc <= acc + addend when en, synchronous clear.
//   clk, rstn : clock, async active-low reset
//   en        : advance the accumulator
//   clear     : zero the accumulator (wins over en)
//   addend    : value added this update
//   acc       : registered accumulator
//   ovf_c     : overflow of the update that en would commit this cycle
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 16,
  parameter cic_mode_e   MODE      = CIC_WRAP
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        clear,
  input  logic signed [ACC_WIDTH-1:0] addend,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        ovf_c
);

  cic_add_t res;
  logic     unused_sum_bits;

  // Candidate update and its overflow.
  always_comb begin
    res   = add_ovf(CIC_MAX_W'(acc), CIC_MAX_W'(addend), ACC_WIDTH, MODE);
    ovf_c = res.ovf;
  end

  // Bits of the wide sum above ACC_WIDTH are don't-care.
  assign unused_sum_bits = ^res.sum;

  // Accumulator register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= ACC_WIDTH'(res.sum);
    end
  end

endmodule

// File: rtl/cic_integrator_chain.sv
// Cascade of N_STAGES signed integrators sharing one sample enable.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of cic_integrator_chain_if
//               in_valid/in_data sample, clear (accumulators), clr_ovf (sticky flags),
//               out_valid/out_data last-stage result, ovf_pulse/ovf_sticky per-stage overflow
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned N_STAGES  = 3,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  cic_integrator_chain_if.slave  bus
);

  localparam cic_mode_e MODE = (SATURATE != 0) ? CIC_SAT : CIC_WRAP;

  // Parameter legality.
  if (ACC_WIDTH < IN_WIDTH) begin : g_bad_acc_width
    $error("cic_integrator_chain: ACC_WIDTH must be >= IN_WIDTH");
  end
  if (ACC_WIDTH > CIC_MAX_W) begin : g_bad_max_width
    $error("cic_integrator_chain: ACC_WIDTH exceeds CIC_MAX_W");
  end
  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
    $error("cic_integrator_chain: N_STAGES must be 1..8");
  end

  logic signed [ACC_WIDTH-1:0] acc    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] addend [N_STAGES];
  logic [N_STAGES-1:0]         stage_ovf_c;
  logic [N_STAGES-1:0]         new_ovf_c;
  logic                        upd_c;
  logic                        out_valid;
  logic [N_STAGES-1:0]         ovf_pulse;
  logic [N_STAGES-1:0]         ovf_sticky;

  // A sample is committed only when valid and not discarded by clear.
  assign upd_c     = bus.in_valid & ~bus.clear;
  assign new_ovf_c = upd_c ? stage_ovf_c : '0;

  // Stage k adds the pre-update value of stage k-1; stage 0 adds the sign-extended sample.
  for (genvar k = 0; k < int'(N_STAGES); k++) begin : g_stage
    if (k == 0) begin : g_first
      assign addend[k] = ACC_WIDTH'(bus.in_data);
    end else begin : g_next
      assign addend[k] = acc[k-1];
    end

    cic_integrator_stage #(
      .ACC_WIDTH (ACC_WIDTH),
      .MODE      (MODE)
    ) u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .en     (bus.in_valid),
      .clear  (bus.clear),
      .addend (addend[k]),
      .acc    (acc[k]),
      .ovf_c  (stage_ovf_c[k])
    );
  end

  // Valid, overflow pulse and sticky flags; a new overflow wins over clr_ovf.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      ovf_pulse  <= '0;
      ovf_sticky <= '0;
    end else begin
      out_valid  <= upd_c;
      ovf_pulse  <= new_ovf_c;
      ovf_sticky <= (bus.clr_ovf ? '0 : ovf_sticky) | new_ovf_c;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = acc[N_STAGES-1];
  assign bus.ovf_pulse  = ovf_pulse;
  assign bus.ovf_sticky = ovf_sticky;

endmodule

// File: doc/cic_integrator_chain.md
# cic_integrator_chain

Parametrised multi-stage integrator section for the CIC decimation filter. Cascades N_STAGES signed accumulators with a shared sample-enable, selectable wrap-around or saturating arithmetic, and per-stage sticky overflow reporting. Sits between the input sample source and the decimator/comb section. Generalises the single-stage unsigned integrator to N stages, two's-complement data, configurable accumulator width and an arithmetic mode.

## Interface
- IN_WIDTH, 8, input sample width (signed)
- ACC_WIDTH, 16, accumulator width of every stage; must be >= IN_WIDTH, otherwise elaboration error
- N_STAGES, 3, number of cascaded integrators; must be 1..8
- SATURATE, 0, 0 = modular wrap (CIC-correct), 1 = clamp to signed min/max
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample enable; all stages advance only when high
- in_data  in  IN_WIDTH  signed input sample
- clear  in  1  synchronous clear of accumulators and out_valid
- clr_ovf  in  1  synchronous clear of ovf_sticky
- out_valid  out  1  out_data updated this cycle
- out_data  out  ACC_WIDTH  last-stage accumulator, signed
- ovf_pulse  out  N_STAGES  bit k high for one cycle when stage k overflowed on the last update
- ovf_sticky  out  N_STAGES  bit k latched high after any overflow of stage k

## Operation
- in_data is sign-extended to ACC_WIDTH before stage 0.
- On a cycle with in_valid=1, all stages update simultaneously from pre-update values: acc[0] <= acc[0] + x; acc[k] <= acc[k] + acc[k-1] for k >= 1.
- in_valid=0: all accumulators, out_data and ovf_sticky hold; out_valid and ovf_pulse go to 0 next cycle.
- Overflow for stage k: both operands same sign, raw sum sign differs.
- SATURATE=0: result is the raw ACC_WIDTH sum, wrap-around discarded; flags still set.
- SATURATE=1: result clamps to 2^(ACC_WIDTH-1)-1 on positive overflow, -2^(ACC_WIDTH-1) on negative overflow; the clamped value feeds the next stage.
- clear=1: all acc, out_data, out_valid, ovf_pulse go to 0 next cycle; clear beats simultaneous in_valid (sample discarded). ovf_sticky is not affected by clear.
- clr_ovf=1: ovf_sticky goes to 0 next cycle, unless an overflow occurs the same cycle, in which case set wins.

## Timing
- Reset: every acc, out_data, out_valid, ovf_pulse and ovf_sticky = 0; takes effect immediately; reset mid-operation discards all state.
- Latency: out_valid and out_data are registered one cycle after the in_valid cycle; out_data = acc[N_STAGES-1].
- Impulse response: a sample appears at the output after N_STAGES valid updates.
- ovf_pulse is aligned with out_valid of the same update.
- No backpressure; in_valid may be high every cycle.

## Structure
- Package cic_pkg: typedef cic_mode_e {CIC_WRAP, CIC_SAT}; function add_ovf (returns sum and overflow flag, with optional clamp); shared with the comb section.
- Sub-module cic_integrator_stage: one accumulator with enable, clear, mode and overflow outputs; the top level instantiates it with a generate loop and adds the valid and sticky logic.

## Test plan
- Impulse, N_STAGES=3: in_data=1 then zeros, in_valid continuous -> out_data sequence 0,0,1,3,6,10,15, one cycle after each input.
- Stall: same impulse with in_valid low every other cycle -> identical value sequence, output changes only after valid cycles, out_valid matches in_valid delayed by 1.
- Wrap mode, IN_WIDTH=8, ACC_WIDTH=8, N_STAGES=1: constant 127 for two samples -> 127, then -2; ovf_pulse[0] pulses once, ovf_sticky[0] stays 1.
- Saturate mode, same stimulus -> 127, 127; then -128 repeated -> value drops and clamps at -128; ovf_sticky[0]=1.
- clear together with in_valid and in_data=5 -> next cycle out_valid=0, all acc=0, ovf_sticky unchanged; clr_ovf together with a new overflow -> ovf_sticky stays 1.
- Asynchronous reset mid-stream with nonzero accumulators -> all outputs 0 immediately; first post-reset impulse reproduces the triangular sequence.
